// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with req/ack memory port, 2-entry buffer and branch redirect; IF_FETCH_PERF_EN adds fetch/bubble counters
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic [31:0] BranchPC_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] PC_o,
    output logic [31:0] Inst_o,
    output logic        Flush_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_t;
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] pc_q [2];
    logic [31:0] pc_d [2];
    logic [31:0] inst_q [2];
    logic [31:0] inst_d [2];
    logic [1:0]  count_q, count_d;
    logic        push, pop, wr_idx;
    assign push    = (state_q == FETCH) && imem_ack_i && !Branch_i;
    assign pop     = !Stall_i && !Branch_i && (count_q != 2'd0);
    assign wr_idx  = count_q[0] ^ pop;
    assign Flush_o = Branch_i;
    assign PC_o    = (count_q != 2'd0) ? pc_q[0] : '0;
    assign Inst_o  = (count_q != 2'd0) ? inst_q[0] : '0;
    // buffer: a branch squashes everything; otherwise shift on pop and write behind the survivors
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = Branch_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            pc_d[0]   = pc_q[1];
            inst_d[0] = inst_q[1];
        end
        if (push) begin
            pc_d[wr_idx]   = fetch_pc_q;
            inst_d[wr_idx] = imem_data_i;
        end
    end
    // fetch FSM: a redirect during an unanswered request parks in DROP on the stale address until its ack
    always_comb begin
        imem_req_o  = (state_q == FETCH) || (state_q == DROP);
        imem_addr_o = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
        drop_addr_d = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
        fetch_pc_d  = Branch_i ? BranchPC_i : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        state_d     = (state_q == IDLE) ? FETCH :
                      (state_q == DROP) ? (imem_ack_i ? FETCH : DROP) :
                      (state_q == FETCH && Branch_i && !imem_ack_i) ? DROP :
                      (count_d == 2'd2) ? WAIT : FETCH;
    end
    // state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= 2'd0;
            pc_q        <= '{default: '0};
            inst_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
        end
    end
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;
    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    // counts accepted fetches and unstalled bubble cycles, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {31'd0, push};
            bubble_cnt_q <= bubble_cnt_q + {31'd0, !Stall_i && (Inst_o == 32'd0)};
        end
    end
`endif
endmodule
